// File: rtl/pa_trace_pkg.sv
// Shared definitions for the writeback trace path: default widths, the trace
// entry layout and field offsets used by host-side unpacking.
package pa_trace_pkg;

    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_TS_W   = 16;

    typedef struct packed {
        logic [DEF_TS_W-1:0]   ts;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] val;
    } trace_entry_t;

    // Bit offsets of each field inside a packed {ts, addr, val} entry
    localparam int unsigned VAL_LSB  = 0;
    localparam int unsigned ADDR_LSB = DEF_DATA_W;
    localparam int unsigned TS_LSB   = DEF_DATA_W + DEF_ADDR_W;
    localparam int unsigned ENTRY_W  = DEF_TS_W + DEF_ADDR_W + DEF_DATA_W;

endpackage

// File: rtl/wb_trace_fifo.sv
// Generic show-ahead synchronous FIFO with push/pop/clear and occupancy level.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module wb_trace_fifo #(
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [LVL_W-1:0] level_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_eff;
    logic             pop_eff;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign level_o = level_q;
    // Gated so the head reads zero whenever nothing is buffered
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        pop_eff  = pop_i && !empty_o;
        push_eff = push_i && (!full_o || pop_eff);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear_i) begin
            pop_eff  = 1'b0;
            push_eff = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_eff) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_eff)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_eff, pop_eff})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push_eff) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/wb_trace_collector.sv
// Timestamps core writeback events, buffers them for a valid/ready consumer and
// counts drops on overflow. Optional shadow register file under WB_TRACE_SHADOW_EN.
module wb_trace_collector
    import pa_trace_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned TS_W   = DEF_TS_W
) (
    input  logic                             clock_i,
    input  logic                             reset_i,
    input  logic                             wb_i,
    input  logic [ADDR_W-1:0]                wbAddr_i,
    input  logic [DATA_W-1:0]                wbVal_i,
    input  logic                             clear_i,
    output logic                             traceValid_o,
    output logic [TS_W+ADDR_W+DATA_W-1:0]    traceData_o,
    input  logic                             traceReady_i,
    output logic [$clog2(DEPTH+1)-1:0]       level_o,
    output logic                             overflow_o,
    output logic [7:0]                       dropCount_o,
    input  logic [ADDR_W-1:0]                shadowAddr_i,
    output logic [DATA_W-1:0]                shadowData_o
);

    localparam int unsigned E_W = TS_W + ADDR_W + DATA_W;

    logic [TS_W-1:0] ts_q, ts_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;
    logic            fifo_full;
    logic            fifo_empty;
    logic            drop;

    wb_trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (E_W)
    ) u_fifo (
        .clk_i   (clock_i),
        .rst_i   (reset_i),
        .clear_i (clear_i),
        .push_i  (wb_i),
        .pop_i   (traceReady_i),
        .wdata_i ({ts_q, wbAddr_i, wbVal_i}),
        .rdata_o (traceData_o),
        .level_o (level_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign traceValid_o = !fifo_empty;
    assign overflow_o   = overflow_q;
    assign dropCount_o  = drop_cnt_q;

    always_comb begin
        ts_d       = ts_q + TS_W'(1);
        // When full, a ready consumer always frees the slot the event needs
        drop       = wb_i && fifo_full && !traceReady_i;
        overflow_d = overflow_q | drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 8'd1;
        if (clear_i) begin
            ts_d       = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ts_q       <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

`ifdef WB_TRACE_SHADOW_EN
    logic [DATA_W-1:0] shadow_q [2**ADDR_W];

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < 2**ADDR_W; i++) shadow_q[i] <= '0;
        end else if (wb_i) begin
            shadow_q[wbAddr_i] <= wbVal_i;
        end
    end

    assign shadowData_o = shadow_q[shadowAddr_i];
`else
    logic unused_shadow_addr;
    assign unused_shadow_addr = ^shadowAddr_i;
    assign shadowData_o       = '0;
`endif

endmodule

// File: tb/tb_wb_trace_collector.sv
// Randomized and directed bench for wb_trace_collector against a queue-based model;
// a second instance with 4-bit timestamps exercises counter wrap.
module tb_wb_trace_collector;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        wb_i = 1'b0;
    logic [4:0]  addr_i = '0;
    logic [15:0] val_i = '0;
    logic        clr_i = 1'b0;
    logic        rdy_i = 1'b0;
    logic [4:0]  saddr_i = '0;

    logic        valid16, valid4;
    logic [36:0] data16;
    logic [24:0] data4;
    logic [3:0]  level16, level4;
    logic        ovf16, ovf4;
    logic [7:0]  drops16, drops4;
    logic [15:0] shadow16, shadow4;

    always #5 clk = ~clk;

    wb_trace_collector #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(16), .TS_W(16)) dut (
        .clock_i(clk), .reset_i(rst_i), .wb_i(wb_i), .wbAddr_i(addr_i), .wbVal_i(val_i),
        .clear_i(clr_i), .traceValid_o(valid16), .traceData_o(data16), .traceReady_i(rdy_i),
        .level_o(level16), .overflow_o(ovf16), .dropCount_o(drops16),
        .shadowAddr_i(saddr_i), .shadowData_o(shadow16)
    );

    wb_trace_collector #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(16), .TS_W(4)) dut_ts4 (
        .clock_i(clk), .reset_i(rst_i), .wb_i(wb_i), .wbAddr_i(addr_i), .wbVal_i(val_i),
        .clear_i(clr_i), .traceValid_o(valid4), .traceData_o(data4), .traceReady_i(rdy_i),
        .level_o(level4), .overflow_o(ovf4), .dropCount_o(drops4),
        .shadowAddr_i(saddr_i), .shadowData_o(shadow4)
    );

    typedef struct {
        int unsigned ts;
        logic [4:0]  a;
        logic [15:0] v;
    } ent_t;

    ent_t        q_m[$];
    int unsigned ts_m;
    logic        ovf_m;
    int unsigned drops_m;
    logic [15:0] shadow_m [32];

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_shadow(input logic [4:0] a);
`ifdef WB_TRACE_SHADOW_EN
        return shadow_m[a];
`else
        return 16'h0;
`endif
    endfunction

    task automatic model_edge();
        logic popped;
        if (rst_i) begin
            q_m.delete();
            ts_m = 0; ovf_m = 1'b0; drops_m = 0;
            for (int i = 0; i < 32; i++) shadow_m[i] = 16'h0;
            return;
        end
        if (wb_i) shadow_m[addr_i] = val_i;
        if (clr_i) begin
            q_m.delete();
            ts_m = 0; ovf_m = 1'b0; drops_m = 0;
            return;
        end
        popped = rdy_i && (q_m.size() > 0);
        if (popped) void'(q_m.pop_front());
        if (wb_i) begin
            if (q_m.size() < DEPTH) begin
                q_m.push_back('{ts: ts_m, a: addr_i, v: val_i});
            end else begin
                ovf_m = 1'b1;
                if (drops_m < 255) drops_m++;
            end
        end
        ts_m++;
    endtask

    task automatic check_outputs();
        logic [36:0] e16;
        logic [24:0] e4;
        logic [31:0] t;
        e16 = '0;
        e4  = '0;
        if (q_m.size() > 0) begin
            t   = q_m[0].ts;
            e16 = {t[15:0], q_m[0].a, q_m[0].v};
            e4  = {t[3:0], q_m[0].a, q_m[0].v};
        end
        check("valid", 64'(valid16), 64'(q_m.size() != 0));
        check("data", 64'(data16), 64'(e16));
        check("data_ts4", 64'(data4), 64'(e4));
        check("level", 64'(level16), 64'(q_m.size()));
        check("overflow", 64'(ovf16), 64'(ovf_m));
        check("drops", 64'(drops16), 64'(drops_m));
    endtask

    task automatic step(input logic wb, input logic [4:0] a, input logic [15:0] v,
                        input logic rdy, input logic clr, input logic rst, input logic [4:0] sa);
        @(negedge clk);
        wb_i = wb; addr_i = a; val_i = v; rdy_i = rdy; clr_i = clr; rst_i = rst; saddr_i = sa;
        #1;
        check("shadow_rd", 64'(shadow16), 64'(exp_shadow(sa)));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 5'd0, 16'h0, rdy, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic event_(input logic rdy);
        step(1'b1, 5'($urandom), 16'($urandom), rdy, 1'b0, 1'b0, 5'($urandom));
    endtask

    initial begin
        logic [15:0] shadow_exp;

        // Reset and the reset-state outputs
        step(1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b1, 5'd0);
        step(1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b1, 5'd0);
        check("rst_valid", 64'(valid16), 64'd0);
        check("rst_data", 64'(data16), 64'd0);

        // Single event in cycle 3 after reset
        repeat (3) idle(1'b0);
        step(1'b1, 5'd5, 16'h1234, 1'b0, 1'b0, 1'b0, 5'd0);
        check("first_valid", 64'(valid16), 64'd1);
        check("first_data", 64'(data16), 64'({16'd3, 5'd5, 16'h1234}));
        check("first_level", 64'(level16), 64'd1);
        idle(1'b1);
        check("first_pop_level", 64'(level16), 64'd0);

        // Overflow by two while stalled, then drain
        repeat (10) event_(1'b0);
        check("ovf_level", 64'(level16), 64'd8);
        check("ovf_flag", 64'(ovf16), 64'd1);
        check("ovf_drops", 64'(drops16), 64'd2);
        repeat (8) idle(1'b1);

        // Full FIFO with simultaneous push and pop every cycle
        repeat (8) event_(1'b0);
        repeat (20) event_(1'b1);
        check("stream_level", 64'(level16), 64'd8);
        check("stream_drops", 64'(drops16), 64'd2);

        // Drop counter saturation, then clear
        repeat (300) event_(1'b0);
        check("sat_drops", 64'(drops16), 64'd255);
        step(1'b1, 5'd1, 16'h1, 1'b1, 1'b1, 1'b0, 5'd0);
        check("clr_level", 64'(level16), 64'd0);
        check("clr_ovf", 64'(ovf16), 64'd0);
        check("clr_drops", 64'(drops16), 64'd0);

        // Timestamp restart from 0 and 4-bit wrap at 15 -> 0
        repeat (15) idle(1'b0);
        step(1'b1, 5'd2, 16'hAAAA, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b1, 5'd3, 16'h5555, 1'b0, 1'b0, 1'b0, 5'd0);
        check("wrap_ts16_a", 64'(data16[36:21]), 64'd15);
        check("wrap_ts4_a", 64'(data4[24:21]), 64'd15);
        idle(1'b1);
        check("wrap_ts16_b", 64'(data16[36:21]), 64'd16);
        check("wrap_ts4_b", 64'(data4[24:21]), 64'd0);
        idle(1'b1);

        // Shadow file: old value in write cycle, new value after, survives clear
`ifdef WB_TRACE_SHADOW_EN
        shadow_exp = 16'hBEEF;
`else
        shadow_exp = 16'h0;
`endif
        step(1'b1, 5'd7, 16'hBEEF, 1'b0, 1'b0, 1'b0, 5'd7);
        check("shadow_new", 64'(shadow16), 64'(shadow_exp));
        repeat (12) step(1'b1, 5'd9, 16'($urandom), 1'b0, 1'b0, 1'b0, 5'd7);
        step(1'b0, 5'd0, 16'h0, 1'b0, 1'b1, 1'b0, 5'd7);
        check("shadow_after_clear", 64'(shadow16), 64'(shadow_exp));
        step(1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b1, 5'd7);
        check("shadow_after_reset", 64'(shadow16), 64'd0);

        // Randomized traffic, with occasional clear and reset
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 5'($urandom), 16'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 60) == 0,
                 $urandom_range(0, 150) == 0, 5'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
